// File: rtl/axi4_lite_cmd_master_pkg.sv
// Shared types and constants for the AXI4-Lite command master:
// FSM state encoding, AXI response codes, default bus widths.
package axi4_lite_cmd_master_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int LAT_W      = 16;

    localparam logic [LAT_W-1:0] LAT_MAX = 16'hFFFF;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RSP     = 3'd5
    } state_e;

    function automatic logic [LAT_W-1:0] lat_sat_inc(input logic [LAT_W-1:0] v);
        return (v == LAT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding AXI4-Lite manager: turns one command into one AW/W/B or
// AR/R exchange and returns a response with the accept-to-handshake latency.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | o_cmd_ready high, waiting for a command
// ST_WR_REQ  | awvalid/wvalid asserted, each dropped after its own handshake
// ST_WR_RESP | bready high, waiting for bvalid
// ST_RD_REQ  | arvalid asserted until arready
// ST_RD_RESP | rready high, waiting for rvalid
// ST_RSP     | o_rsp_valid high with captured fields until i_rsp_ready
module axi4_lite_cmd_master
    import axi4_lite_cmd_master_pkg::*;
#(
    parameter int AXI4_LITE_ADDR_BIT_WIDTH = DEF_ADDR_W,
    parameter int AXI4_LITE_DATA_BIT_WIDTH = DEF_DATA_W
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,

    input  logic                                  i_cmd_valid,
    output logic                                  o_cmd_ready,
    input  logic                                  i_cmd_we,
    input  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   i_cmd_addr,
    input  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   i_cmd_wdata,
    input  logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0] i_cmd_wstrb,

    output logic                                  o_rsp_valid,
    input  logic                                  i_rsp_ready,
    output logic                                  o_rsp_we,
    output logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   o_rsp_rdata,
    output logic [1:0]                            o_rsp_resp,
    output logic [LAT_W-1:0]                      o_rsp_latency,

    output logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   o_awaddr,
    output logic [2:0]                            o_awprot,
    output logic                                  o_awvalid,
    input  logic                                  i_awready,

    output logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   o_wdata,
    output logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0] o_wstrb,
    output logic                                  o_wvalid,
    input  logic                                  i_wready,

    input  logic [1:0]                            i_bresp,
    input  logic                                  i_bvalid,
    output logic                                  o_bready,

    output logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   o_araddr,
    output logic [2:0]                            o_arprot,
    output logic                                  o_arvalid,
    input  logic                                  i_arready,

    input  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   i_rdata,
    input  logic [1:0]                            i_rresp,
    input  logic                                  i_rvalid,
    output logic                                  o_rready
);

    localparam int AW = AXI4_LITE_ADDR_BIT_WIDTH;
    localparam int DW = AXI4_LITE_DATA_BIT_WIDTH;
    localparam int SW = DW / 8;

    if (!(DW == 32 || DW == 64)) begin : g_bad_data_width
        $error("AXI4_LITE_DATA_BIT_WIDTH must be 32 or 64");
    end

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [SW-1:0]     wstrb_q, wstrb_d;
    logic              we_q, we_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [1:0]        resp_q, resp_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [LAT_W-1:0]  lat_cap_q, lat_cap_d;

    logic awvalid, wvalid, arvalid, bready, rready;

    // Handshake strobes are decoded from registered state only, so reset
    // drops every VALID/READY without waiting for a clock.
    assign o_cmd_ready = (state_q == ST_IDLE);
    assign awvalid     = (state_q == ST_WR_REQ) && !aw_done_q;
    assign wvalid      = (state_q == ST_WR_REQ) && !w_done_q;
    assign bready      = (state_q == ST_WR_RESP);
    assign arvalid     = (state_q == ST_RD_REQ);
    assign rready      = (state_q == ST_RD_RESP);
    assign o_rsp_valid = (state_q == ST_RSP);

    assign o_awvalid = awvalid;
    assign o_wvalid  = wvalid;
    assign o_bready  = bready;
    assign o_arvalid = arvalid;
    assign o_rready  = rready;

    assign o_awaddr = addr_q;
    assign o_araddr = addr_q;
    assign o_wdata  = wdata_q;
    assign o_wstrb  = wstrb_q;
    assign o_awprot = AXI_PROT_DEFAULT;
    assign o_arprot = AXI_PROT_DEFAULT;

    assign o_rsp_we      = we_q;
    assign o_rsp_rdata   = rdata_q;
    assign o_rsp_resp    = resp_q;
    assign o_rsp_latency = lat_cap_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            we_q      <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            lat_q     <= '0;
            lat_cap_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            we_q      <= we_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            lat_q     <= lat_d;
            lat_cap_q <= lat_cap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        we_d      = we_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        lat_d     = lat_q;
        lat_cap_d = lat_cap_q;

        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    addr_d    = i_cmd_addr;
                    wdata_d   = i_cmd_wdata;
                    wstrb_d   = i_cmd_wstrb;
                    we_d      = i_cmd_we;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    lat_d     = 16'd1;
                    state_d   = i_cmd_we ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                lat_d = lat_sat_inc(lat_q);
                if (awvalid && i_awready) aw_done_d = 1'b1;
                if (wvalid && i_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                lat_d = lat_sat_inc(lat_q);
                if (i_bvalid) begin
                    resp_d    = i_bresp;
                    rdata_d   = '0;
                    lat_cap_d = lat_sat_inc(lat_q);
                    state_d   = ST_RSP;
                end
            end
            ST_RD_REQ: begin
                lat_d = lat_sat_inc(lat_q);
                if (i_arready) state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                lat_d = lat_sat_inc(lat_q);
                if (i_rvalid) begin
                    resp_d    = i_rresp;
                    rdata_d   = i_rdata;
                    lat_cap_d = lat_sat_inc(lat_q);
                    state_d   = ST_RSP;
                end
            end
            ST_RSP: begin
                if (i_rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// Scoreboard bench for axi4_lite_cmd_master: a behavioural subordinate with
// per-transaction wait knobs, a reference memory, and a response monitor.
module tb_axi4_lite_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_we;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [15:0]   rsp_latency;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp, rresp;

    axi4_lite_cmd_master #(
        .AXI4_LITE_ADDR_BIT_WIDTH(AW),
        .AXI4_LITE_DATA_BIT_WIDTH(DW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_we(cmd_we),
        .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_we(rsp_we),
        .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp), .o_rsp_latency(rsp_latency),
        .o_awaddr(awaddr), .o_awprot(awprot), .o_awvalid(awvalid), .i_awready(awready),
        .o_wdata(wdata), .o_wstrb(wstrb), .o_wvalid(wvalid), .i_wready(wready),
        .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready),
        .o_araddr(araddr), .o_arprot(arprot), .o_arvalid(arvalid), .i_arready(arready),
        .i_rdata(rdata), .i_rresp(rresp), .i_rvalid(rvalid), .o_rready(rready)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] new_v,
                                            input logic [SW-1:0] strb);
        logic [DW-1:0] r;
        r = old_v;
        for (int b = 0; b < SW; b++)
            if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    // ---------------- subordinate model ----------------
    int         aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic [1:0] bresp_k = 2'b00, rresp_k = 2'b00;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_wdata = '0;
    logic [SW-1:0] cur_wstrb = '0;

    logic [DW-1:0] sub_mem [0:255] = '{default: '0};
    int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic          aw_done, w_done, b_pend, r_pend;
    logic [AW-1:0] aw_addr_s;
    logic [DW-1:0] w_data_s, r_data_s;
    logic [SW-1:0] w_strb_s;
    logic [1:0]    b_resp_s, r_resp_s;
    logic          aw_hs, w_hs, ar_hs;

    assign awready = awvalid && (aw_cnt >= aw_wait);
    assign wready  = wvalid && (w_cnt >= w_wait);
    assign arready = arvalid && (ar_cnt >= ar_wait);
    assign bvalid  = b_pend && (b_cnt >= b_wait);
    assign rvalid  = r_pend && (r_cnt >= r_wait);
    assign bresp   = bvalid ? b_resp_s : 2'b00;
    assign rresp   = rvalid ? r_resp_s : 2'b00;
    assign rdata   = rvalid ? r_data_s : '0;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_done <= 1'b0; w_done <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            aw_addr_s <= '0; w_data_s <= '0; w_strb_s <= '0;
            b_resp_s <= 2'b00; r_resp_s <= 2'b00; r_data_s <= '0;
        end else begin
            if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
            if (wvalid && !wready)   w_cnt <= w_cnt + 1;
            if (arvalid && !arready) ar_cnt <= ar_cnt + 1;
            if (aw_hs) begin aw_cnt <= 0; aw_done <= 1'b1; aw_addr_s <= awaddr; end
            if (w_hs)  begin w_cnt <= 0; w_done <= 1'b1; w_data_s <= wdata; w_strb_s <= wstrb; end
            if ((aw_hs || w_hs) && (aw_done || aw_hs) && (w_done || w_hs)) begin
                aw_done  <= 1'b0;
                w_done   <= 1'b0;
                b_pend   <= 1'b1;
                b_cnt    <= 0;
                b_resp_s <= bresp_k;
                if (bresp_k == 2'b00) begin
                    sub_mem[(aw_hs ? awaddr[9:2] : aw_addr_s[9:2])] <=
                        merge(sub_mem[(aw_hs ? awaddr[9:2] : aw_addr_s[9:2])],
                              (w_hs ? wdata : w_data_s), (w_hs ? wstrb : w_strb_s));
                end
            end
            if (b_pend && !bvalid) b_cnt <= b_cnt + 1;
            if (bvalid && bready) b_pend <= 1'b0;
            if (ar_hs) begin
                ar_cnt   <= 0;
                r_pend   <= 1'b1;
                r_cnt    <= 0;
                r_resp_s <= rresp_k;
                r_data_s <= sub_mem[araddr[9:2]];
            end
            if (r_pend && !rvalid) r_cnt <= r_cnt + 1;
            if (rvalid && rready) r_pend <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic          we;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
        logic [15:0]   lat;
    } exp_t;
    exp_t exp_q[$];
    logic [DW-1:0] ref_mem [0:255] = '{default: '0};

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (aw_hs) begin
                    chk("awaddr", 64'(awaddr), 64'(cur_addr));
                    chk("awprot", 64'(awprot), 64'd0);
                end
                if (w_hs) begin
                    chk("wdata", 64'(wdata), 64'(cur_wdata));
                    chk("wstrb", 64'(wstrb), 64'(cur_wstrb));
                end
                if (ar_hs) begin
                    chk("araddr", 64'(araddr), 64'(cur_addr));
                    chk("arprot", 64'(arprot), 64'd0);
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("rsp_we", 64'(rsp_we), 64'(e.we));
                        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                        chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
                        chk("rsp_latency", 64'(rsp_latency), 64'(e.lat));
                    end
                end
            end
        end
    end

    logic hold_rdy = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Expected latency: accept counts as 1, each request wait adds a cycle,
    // the B/R beat arrives one cycle after the request completes.
    task automatic issue(input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [SW-1:0] strb);
        int   g;
        exp_t e;
        int   lat;
        g = 0;
        while (!cmd_ready && g < 1000) begin @(posedge clk); #1; g++; end
        if (g >= 1000) fail_now("cmd_ready_wait");
        cur_addr  = addr;
        cur_wdata = data;
        cur_wstrb = strb;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        e.we = we;
        if (we) begin
            lat = 3 + ((aw_wait > w_wait) ? aw_wait : w_wait) + b_wait;
            e.rdata = '0;
            e.resp  = bresp_k;
            if (bresp_k == 2'b00)
                ref_mem[addr[9:2]] = merge(ref_mem[addr[9:2]], data, strb);
        end else begin
            lat = 3 + ar_wait + r_wait;
            e.rdata = ref_mem[addr[9:2]];
            e.resp  = rresp_k;
        end
        e.lat = (lat > 65535) ? 16'hFFFF : 16'(lat);
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int limit);
        int g;
        g = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && g < limit) begin
            @(posedge clk); #1; g++;
        end
        if (g >= limit) begin
            fail_now("rsp_wait");
            exp_q.delete();
        end
    endtask

    task automatic set_waits(input int a, input int w, input int b,
                             input int ar, input int r);
        aw_wait = a; w_wait = w; b_wait = b; ar_wait = ar; r_wait = r;
    endtask

    initial begin
        int g;
        // reset values
        #2;
        chk("rst_awvalid", 64'(awvalid), 64'd0);
        chk("rst_wvalid", 64'(wvalid), 64'd0);
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_bready", 64'(bready), 64'd0);
        chk("rst_rready", 64'(rready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_latency", 64'(rsp_latency), 64'd0);
        chk("rst_rdata", 64'(rsp_rdata), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // zero-wait write: AW and W in the same cycle, latency 3
        set_waits(0, 0, 0, 0, 0);
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        chk("zw_awvalid", 64'(awvalid), 64'd1);
        chk("zw_wvalid", 64'(wvalid), 64'd1);
        @(posedge clk); #1;
        wait_idle(200);

        // awready five cycles after the W handshake
        set_waits(5, 0, 0, 0, 0);
        issue(1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF);
        @(negedge clk);
        chk("split_w_first", 64'(wvalid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("split_wvalid_dropped", 64'(wvalid), 64'd0);
            chk("split_awvalid_held", 64'(awvalid), 64'd1);
        end
        @(posedge clk); #1;
        wait_idle(200);

        // read back
        set_waits(0, 0, 0, 0, 0);
        issue(1'b0, 32'h0000_0010, '0, '0);
        wait_idle(200);

        // SLVERR read while the consumer stalls
        hold_rdy = 1'b1;
        rresp_k  = 2'b10;
        set_waits(0, 0, 0, 1, 2);
        issue(1'b0, 32'h0000_0010, '0, '0);
        g = 0;
        while (!rsp_valid && g < 200) begin @(negedge clk); g++; end
        if (g >= 200) fail_now("slverr_rsp_valid");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("stall_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
            chk("stall_resp", 64'(rsp_resp), 64'd2);
            chk("stall_we", 64'(rsp_we), 64'd0);
            chk("stall_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        hold_rdy = 1'b0;
        rresp_k  = 2'b00;
        wait_idle(200);

        // reset while waiting for B: silent abandon
        set_waits(0, 1, 20, 0, 0);
        issue(1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'hF);
        g = 0;
        while (!bready && g < 100) begin @(negedge clk); g++; end
        if (g >= 100) fail_now("reset_bready_wait");
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bready", 64'(bready), 64'd0);
        chk("mid_rst_awvalid", 64'(awvalid), 64'd0);
        chk("mid_rst_wvalid", 64'(wvalid), 64'd0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        set_waits(0, 0, 0, 0, 0);
        issue(1'b1, 32'h0000_0040, 32'h0BAD_F00D, 4'h5);
        wait_idle(200);
        issue(1'b0, 32'h0000_0030, '0, '0);
        wait_idle(200);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            logic          we;
            logic [AW-1:0] addr;
            set_waits($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                      $urandom_range(0, 4), $urandom_range(0, 4));
            bresp_k = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rresp_k = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            we   = ($urandom_range(0, 1) == 1);
            addr = 32'($urandom_range(0, 15)) << 2;
            issue(we, addr, $urandom, 4'($urandom_range(1, 15)));
            wait_idle(500);
        end
        bresp_k = 2'b00;
        rresp_k = 2'b00;

        // B stalled long enough to saturate the latency counter
        set_waits(0, 0, 70000, 0, 0);
        issue(1'b1, 32'h0000_0050, 32'h5555_AAAA, 4'hF);
        wait_idle(80000);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
